inst_fetch_ctrl: RTL and testbench

- Consumer side of the PC register.
  - Takes the current PC value and issues one instruction read per PC on the SRAM-like instruction bus.
  - Holds the returned word for decode.
  - Drives the PC register's enable.
- Sits between the PC register and the IF/ID stage.
- Handles decode back-pressure and branch/exception redirect (flush) with in-flight request discard.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/inst_fetch_ctrl_if.sv | 26 ++
 rtl/fetch_perf_cnt.sv | 21 ++
 rtl/inst_fetch_ctrl.sv | 122 ++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StData,
        StHold,
        StDrop
    } fetch_state_e;

    localparam logic [31:0] RESET_PC       = 32'hbfc00000;
    localparam logic [1:0]  INST_SIZE_WORD = 2'b10;

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// SRAM-like instruction bus: master issues one word read at a time.
interface inst_fetch_ctrl_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);

    logic              inst_req;
    logic              inst_wr;
    logic [1:0]        inst_size;
    logic [ADDR_W-1:0] inst_addr;
    logic [DATA_W-1:0] inst_wdata;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [DATA_W-1:0] inst_rdata;

    modport master (
        output inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
        input  inst_addr_ok, inst_data_ok, inst_rdata
    );

    modport slave (
        input  inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
        output inst_addr_ok, inst_data_ok, inst_rdata
    );

endinterface

// File: rtl/fetch_perf_cnt.sv
// Saturating 32-bit event counter for fetch bus-wait cycles.
module fetch_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_inc,
    output logic [31:0] o_count
);

    logic [31:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= 32'd0;
        end else if (i_inc && (r_count != 32'hffffffff)) begin
            r_count <= r_count + 32'd1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: one bus read per PC, holds the word for decode, drives PC enable.
// Define FETCH_PERF_CNT_EN to count cycles spent waiting on the bus (ADDR/DATA) on perf_wait_o.
module inst_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = fetch_pkg::RESET_PC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  pc_i,
    output logic               pc_en_o,
    input  logic               flush_i,
    input  logic               stall_i,
    inst_fetch_ctrl_if.master  bus,
    output logic [DATA_W-1:0]  inst_o,
    output logic [ADDR_W-1:0]  inst_pc_o,
    output logic               inst_valid_o,
    output logic [31:0]        perf_wait_o
);

    fetch_state_e      r_state;
    fetch_state_e      w_state_next;
    logic              r_flush_pend;
    logic [ADDR_W-1:0] r_req_addr;
    logic [DATA_W-1:0] r_inst;
    logic [ADDR_W-1:0] r_inst_pc;
    logic              r_inst_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (!flush_i) w_state_next = StAddr;
            StAddr: begin
                if (bus.inst_addr_ok) begin
                    w_state_next = (r_flush_pend || flush_i) ? StDrop : StData;
                end
            end
            StData: begin
                if (bus.inst_data_ok) begin
                    w_state_next = flush_i ? StIdle : StHold;
                end else if (flush_i) begin
                    w_state_next = StDrop;
                end
            end
            StHold: if (flush_i || !stall_i) w_state_next = StIdle;
            StDrop: if (bus.inst_data_ok) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        bus.inst_req = (r_state == StAddr);
        // A flush always loads the redirect target, whatever the state.
        pc_en_o      = flush_i || ((r_state == StHold) && !stall_i);
    end

    assign bus.inst_wr    = 1'b0;
    assign bus.inst_size  = INST_SIZE_WORD;
    assign bus.inst_addr  = r_req_addr;
    assign bus.inst_wdata = '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req_addr   <= '0;
            r_flush_pend <= 1'b0;
            r_inst       <= '0;
            r_inst_pc    <= RESET_PC;
            r_inst_valid <= 1'b0;
        end else begin
            // Latching is deferred while flushing so the PC has loaded the target.
            if ((r_state == StIdle) && !flush_i) begin
                r_req_addr <= pc_i;
            end
            if ((r_state == StAddr) && flush_i && !bus.inst_addr_ok) begin
                r_flush_pend <= 1'b1;
            end else if ((r_state == StDrop) && bus.inst_data_ok) begin
                r_flush_pend <= 1'b0;
            end
            if ((r_state == StData) && bus.inst_data_ok && !flush_i) begin
                r_inst       <= bus.inst_rdata;
                r_inst_pc    <= r_req_addr;
                r_inst_valid <= 1'b1;
            end else if ((r_state == StHold) && (flush_i || !stall_i)) begin
                r_inst_valid <= 1'b0;
            end
        end
    end

    assign inst_o       = r_inst;
    assign inst_pc_o    = r_inst_pc;
    assign inst_valid_o = r_inst_valid;

`ifdef FETCH_PERF_CNT_EN
    logic w_in_wait;
    assign w_in_wait = (r_state == StAddr) || (r_state == StData);

    fetch_perf_cnt u_perf_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_in_wait),
        .o_count (perf_wait_o)
    );
`else
    assign perf_wait_o = 32'd0;
`endif

    a_addr_ok_only_in_addr: assert property (@(posedge clk) disable iff (!rst)
        bus.inst_addr_ok |-> (r_state == StAddr));
    a_data_ok_only_when_pending: assert property (@(posedge clk) disable iff (!rst)
        bus.inst_data_ok |-> ((r_state == StData) || (r_state == StDrop)));

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl with a small bus responder and PC register model.
module tb_inst_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        pc_en_o;
    logic        flush_i;
    logic        stall_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_valid_o;
    logic [31:0] perf_wait_o;
    logic [31:0] flush_tgt;

    int unsigned n_checks;
    int unsigned n_errors;
    int unsigned pulses;
    int unsigned p_mark;
    int unsigned addr_wait;
    int unsigned data_wait;
    int unsigned a_cnt;
    int unsigned d_cnt;
    logic        pend;
    logic [31:0] pend_addr;
    logic [31:0] exp_perf;

    inst_fetch_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    inst_fetch_ctrl #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .RESET_PC (32'hbfc00000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc),
        .pc_en_o      (pc_en_o),
        .flush_i      (flush_i),
        .stall_i      (stall_i),
        .bus          (bus),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o),
        .inst_valid_o (inst_valid_o),
        .perf_wait_o  (perf_wait_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        rom = (a == 32'hbfc00000) ? 32'h3c08bfc0 : {16'h2400, a[15:0]};
    endfunction

    // Bus responder: addr_ok after addr_wait request cycles, data_ok data_wait cycles later.
    assign bus.inst_addr_ok = bus.inst_req && (a_cnt >= addr_wait);
    assign bus.inst_data_ok = pend && (d_cnt >= data_wait);
    assign bus.inst_rdata   = bus.inst_data_ok ? rom(pend_addr) : 32'hdeadbeef;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_cnt     <= 0;
            d_cnt     <= 0;
            pend      <= 1'b0;
            pend_addr <= 32'd0;
        end else if (bus.inst_addr_ok) begin
            pend      <= 1'b1;
            pend_addr <= bus.inst_addr;
            d_cnt     <= 0;
            a_cnt     <= 0;
        end else begin
            if (bus.inst_req) a_cnt <= a_cnt + 1;
            if (bus.inst_data_ok) pend <= 1'b0;
            else if (pend) d_cnt <= d_cnt + 1;
        end
    end

    // PC register: +4 per enable, redirect target when flushing.
    always @(posedge clk or negedge rst) begin
        if (!rst) pc <= 32'hbfc00000;
        else if (pc_en_o) pc <= flush_i ? flush_tgt : pc + 32'd4;
    end

    always @(posedge clk) if (rst && pc_en_o) pulses <= pulses + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_req(input string tag, input logic [31:0] exp_addr);
        logic found;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (bus.inst_req) found = 1'b1;
            else check_eq({tag, "_no_valid"}, {31'd0, inst_valid_o}, 32'd0);
        end
        check_eq({tag, "_req_seen"}, {31'd0, found}, 32'd1);
        check_eq({tag, "_addr"}, bus.inst_addr, exp_addr);
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_valid"}, {31'd0, inst_valid_o}, 32'd0);
        check_eq({tag, "_inst"}, inst_o, 32'd0);
        check_eq({tag, "_ipc"}, inst_pc_o, 32'hbfc00000);
        check_eq({tag, "_req"}, {31'd0, bus.inst_req}, 32'd0);
        check_eq({tag, "_addr"}, bus.inst_addr, 32'd0);
        check_eq({tag, "_pcen"}, {31'd0, pc_en_o}, 32'd0);
        check_eq({tag, "_perf"}, perf_wait_o, 32'd0);
        check_eq({tag, "_wr"}, {31'd0, bus.inst_wr}, 32'd0);
        check_eq({tag, "_size"}, {30'd0, bus.inst_size}, 32'd2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_errors = 0; pulses = 0;
        rst = 1'b1; flush_i = 1'b0; stall_i = 1'b0; flush_tgt = 32'd0;
        addr_wait = 0; data_wait = 0;
`ifdef FETCH_PERF_CNT_EN
        exp_perf = 32'd7;
`else
        exp_perf = 32'd0;
`endif
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        check_reset("rst");

        // Zero-wait fetch from reset PC.
        rst = 1'b1;
        @(negedge clk);
        check_eq("t1_req", {31'd0, bus.inst_req}, 32'd1);
        check_eq("t1_addr", bus.inst_addr, 32'hbfc00000);
        check_eq("t1_pcen_addr", {31'd0, pc_en_o}, 32'd0);
        @(negedge clk);
        check_eq("t1_req_data", {31'd0, bus.inst_req}, 32'd0);
        check_eq("t1_valid_data", {31'd0, inst_valid_o}, 32'd0);
        @(negedge clk);
        check_eq("t1_valid", {31'd0, inst_valid_o}, 32'd1);
        check_eq("t1_inst", inst_o, 32'h3c08bfc0);
        check_eq("t1_ipc", inst_pc_o, 32'hbfc00000);
        check_eq("t1_pcen", {31'd0, pc_en_o}, 32'd1);
        addr_wait = 3;
        @(negedge clk);
        check_eq("t1_idle_valid", {31'd0, inst_valid_o}, 32'd0);
        check_eq("t1_pc", pc, 32'hbfc00004);
        p_mark = pulses;

        // addr_ok after 4 request cycles; request held stable.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("t2_req", {31'd0, bus.inst_req}, 32'd1);
            check_eq("t2_addr", bus.inst_addr, 32'hbfc00004);
            check_eq("t2_pcen", {31'd0, pc_en_o}, 32'd0);
        end
        @(negedge clk);
        check_eq("t2_req_data", {31'd0, bus.inst_req}, 32'd0);
        stall_i = 1'b1;
        addr_wait = 0;

        // Stall three cycles in HOLD.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("t3_valid", {31'd0, inst_valid_o}, 32'd1);
            check_eq("t3_inst", inst_o, 32'h24000004);
            check_eq("t3_ipc", inst_pc_o, 32'hbfc00004);
            check_eq("t3_pcen", {31'd0, pc_en_o}, 32'd0);
        end
        check_eq("t2_perf", perf_wait_o, exp_perf);
        check_eq("t3_no_pulse", pulses - p_mark, 32'd0);
        stall_i = 1'b0;
        #1 check_eq("t3_pcen_release", {31'd0, pc_en_o}, 32'd1);
        @(negedge clk);
        check_eq("t3_one_pulse", pulses - p_mark, 32'd1);
        check_eq("t3_pc", pc, 32'hbfc00008);
        check_eq("t3_idle_valid", {31'd0, inst_valid_o}, 32'd0);

        // Flush while waiting for data: data dropped, refetch from target.
        data_wait = 2;
        wait_req("t4a", 32'hbfc00008);
        @(negedge clk);
        p_mark = pulses;
        flush_tgt = 32'hbfc00100;
        flush_i = 1'b1;
        #1 check_eq("t4_pcen", {31'd0, pc_en_o}, 32'd1);
        @(negedge clk);
        flush_i = 1'b0;
        wait_req("t4", 32'hbfc00100);
        check_eq("t4_one_pulse", pulses - p_mark, 32'd1);
        check_eq("t4_inst_kept", inst_o, 32'h24000004);

        // Flush coinciding with data_ok while stalled.
        data_wait = 0;
        @(negedge clk);
        flush_tgt = 32'hbfc00200;
        flush_i = 1'b1;
        stall_i = 1'b1;
        #1 check_eq("t5_pcen", {31'd0, pc_en_o}, 32'd1);
        @(negedge clk);
        flush_i = 1'b0;
        check_eq("t5_valid", {31'd0, inst_valid_o}, 32'd0);
        addr_wait = 2;
        wait_req("t5", 32'hbfc00200);

        // Flush in ADDR before addr_ok: request held, then dropped.
        flush_tgt = 32'hbfc00300;
        flush_i = 1'b1;
        #1 check_eq("t6_pcen", {31'd0, pc_en_o}, 32'd1);
        @(negedge clk);
        flush_i = 1'b0;
        check_eq("t6_req_held", {31'd0, bus.inst_req}, 32'd1);
        check_eq("t6_addr_held", bus.inst_addr, 32'hbfc00200);
        @(negedge clk);
        check_eq("t6_req_held2", {31'd0, bus.inst_req}, 32'd1);
        stall_i = 1'b0;
        addr_wait = 0;
        wait_req("t6", 32'hbfc00300);
        repeat (2) @(negedge clk);
        check_eq("t6_valid", {31'd0, inst_valid_o}, 32'd1);
        check_eq("t6_inst", inst_o, 32'h24000300);
        check_eq("t6_ipc", inst_pc_o, 32'hbfc00300);

        // Reset mid-DATA, then restart.
        wait_req("t7a", 32'hbfc00304);
        @(negedge clk);
        rst = 1'b0;
        #1 check_reset("t7_rst");
        @(negedge clk);
        rst = 1'b1;
        wait_req("t7", 32'hbfc00000);
        repeat (2) @(negedge clk);
        check_eq("t7_valid", {31'd0, inst_valid_o}, 32'd1);
        check_eq("t7_inst", inst_o, 32'h3c08bfc0);
        check_eq("t7_ipc", inst_pc_o, 32'hbfc00000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
